// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit per clock out.
// A single holding register lets a second word queue so consecutive words stream gaplessly.
module bit_serializer #(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_start,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [WIDTH-1:0] hold, hold_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             hold_full, hold_full_nxt;
  logic             accept;
  logic             take_din;

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) return {w[WIDTH-2:0], 1'b0};
    else           return {1'b0, w[WIDTH-1:1]};
  endfunction

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) return w[WIDTH-1];
    else           return w[0];
  endfunction

  assign din_ready = !hold_full;
  assign accept    = din_valid && !hold_full;
  assign busy      = ser_valid | hold_full;

  always_comb begin
    state_nxt     = state;
    sreg_nxt      = sreg;
    cnt_nxt       = cnt;
    hold_nxt      = hold;
    hold_full_nxt = hold_full;
    take_din      = 1'b0;

    case (state)
      S_IDLE: begin
        if (hold_full) begin
          sreg_nxt      = hold;
          hold_full_nxt = 1'b0;
          cnt_nxt       = '0;
          state_nxt     = S_SHIFT;
        end else if (accept) begin
          sreg_nxt  = din;
          take_din  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt == LAST) begin
          cnt_nxt = '0;
          if (hold_full) begin
            sreg_nxt      = hold;
            hold_full_nxt = 1'b0;
          end else if (accept) begin
            sreg_nxt = din;
            take_din = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          cnt_nxt  = cnt + 1'b1;
          sreg_nxt = shift_word(sreg);
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // accept implies hold was empty, so this never collides with a drain
    if (accept && !take_din) begin
      hold_nxt      = din;
      hold_full_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      sreg      <= '0;
      cnt       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      state     <= state_nxt;
      sreg      <= sreg_nxt;
      cnt       <= cnt_nxt;
      hold      <= hold_nxt;
      hold_full <= hold_full_nxt;
    end
  end

  // Outputs are flopped from next-state values so they align with the shifter contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ser_out    <= IDLE_BIT;
      ser_valid  <= 1'b0;
      word_start <= 1'b0;
      word_done  <= 1'b0;
    end else begin
      ser_valid  <= (state_nxt == S_SHIFT);
      ser_out    <= (state_nxt == S_SHIFT) ? head_bit(sreg_nxt) : IDLE_BIT;
      word_start <= (state_nxt == S_SHIFT) && (cnt_nxt == '0);
      word_done  <= (state_nxt == S_SHIFT) && (cnt_nxt == LAST);
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: an MSB-first/idle-0 instance and an LSB-first/idle-1 instance,
// checked every cycle against a word-queue reference model plus directed sequences.
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din_a = '0, din_b = '0;
  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic       ready_a, ser_a, sv_a, ws_a, wd_a, busy_a;
  logic       ready_b, ser_b, sv_b, ws_b, wd_b, busy_b;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .rst(rst), .din(din_a), .din_valid(valid_a), .din_ready(ready_a),
    .ser_out(ser_a), .ser_valid(sv_a), .word_start(ws_a), .word_done(wd_a), .busy(busy_a)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .din(din_b), .din_valid(valid_b), .din_ready(ready_b),
    .ser_out(ser_b), .ser_valid(sv_b), .word_start(ws_b), .word_done(wd_b), .busy(busy_b)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: up to two resident words per instance, head word at bit position mp.
  logic [7:0] mw [2][2];
  int         mn [2] = '{0, 0};
  int         mp [2] = '{0, 0};
  logic       rec0 [$];

  function automatic void mdl_clear();
    for (int d = 0; d < 2; d++) begin
      mn[d] = 0;
      mp[d] = 0;
    end
  endfunction

  function automatic void mdl_step(input int d, input logic v, input logic [7:0] w);
    logic acc;
    acc = v && (mn[d] < 2);
    if (mn[d] > 0) begin
      if (mp[d] == 7) begin
        mw[d][0] = mw[d][1];
        mn[d]--;
        mp[d] = 0;
      end else begin
        mp[d]++;
      end
    end
    if (acc) begin
      mw[d][mn[d]] = w;
      mn[d]++;
    end
  endfunction

  task automatic chk_out(input int d, input logic r, input logic so, input logic sv,
                         input logic st, input logic dn, input logic bz);
    logic       ev, eo, idle;
    logic [7:0] hw;
    idle = (d == 0) ? 1'b0 : 1'b1;
    ev   = (mn[d] > 0);
    hw   = mw[d][0];
    eo   = ev ? ((d == 0) ? hw[7 - mp[d]] : hw[mp[d]]) : idle;
    check($sformatf("d%0d din_ready", d),  r,  mn[d] < 2);
    check($sformatf("d%0d ser_out", d),    so, eo);
    check($sformatf("d%0d ser_valid", d),  sv, ev);
    check($sformatf("d%0d word_start", d), st, ev && mp[d] == 0);
    check($sformatf("d%0d word_done", d),  dn, ev && mp[d] == 7);
    check($sformatf("d%0d busy", d),       bz, ev);
  endtask

  always begin
    @(posedge clk);
    if (rst) mdl_clear();
    else begin
      mdl_step(0, valid_a, din_a);
      mdl_step(1, valid_b, din_b);
    end
    #3;
    if (rst) mdl_clear();
    chk_out(0, ready_a, ser_a, sv_a, ws_a, wd_a, busy_a);
    chk_out(1, ready_b, ser_b, sv_b, ws_b, wd_b, busy_b);
    if (sv_a) rec0.push_back(ser_a);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [7:0] w, output int waited);
    logic r;
    bit   ok;
    ok     = 1'b0;
    waited = 0;
    din_a  = w;
    valid_a = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      r = ready_a;
      step();
      waited++;
      if (r) ok = 1'b1;
    end
    check("send_accept", ok, 1'b1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && (busy_a || busy_b); i++) step();
    check("idle_reached", busy_a | busy_b, 1'b0);
  endtask

  task automatic chk_reset_a(input string tag);
    check({tag, " ser_out"},    ser_a,   1'b0);
    check({tag, " ser_valid"},  sv_a,    1'b0);
    check({tag, " word_start"}, ws_a,    1'b0);
    check({tag, " word_done"},  wd_a,    1'b0);
    check({tag, " busy"},       busy_a,  1'b0);
    check({tag, " din_ready"},  ready_a, 1'b1);
  endtask

  typedef struct {
    logic [7:0] din;
    logic [7:0] seq_msb;  // emission order, bit 7 first
    logic [7:0] seq_lsb;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int         w;
    logic [15:0] got, st, dn;
    logic [23:0] exp24;
    logic [7:0]  exp8;
    int          errs;
    logic        h1, h2, det;

    tbl[0] = '{8'hA5, 8'hA5, 8'hA5};
    tbl[1] = '{8'h01, 8'h01, 8'h80};
    tbl[2] = '{8'h81, 8'h81, 8'h81};
    tbl[3] = '{8'hAA, 8'hAA, 8'h55};
    tbl[4] = '{8'h0F, 8'h0F, 8'hF0};
    tbl[5] = '{8'h6A, 8'h6A, 8'h56};

    #2 rst = 1'b1;
    #1;
    chk_reset_a("reset");
    check("reset b ser_out", ser_b, 1'b1);
    check("reset b din_ready", ready_b, 1'b1);
    step();
    rst = 1'b0;
    step();

    // table of single words, sent to both instances together
    for (int t = 0; t < 6; t++) begin
      check("tbl idle_a before", ser_a, 1'b0);
      check("tbl idle_b before", ser_b, 1'b1);
      din_a = tbl[t].din; din_b = tbl[t].din;
      valid_a = 1'b1; valid_b = 1'b1;
      step();
      valid_a = 1'b0; valid_b = 1'b0;
      for (int i = 0; i < 8; i++) begin
        check($sformatf("tbl%0d msb bit%0d", t, i), ser_a, tbl[t].seq_msb[7 - i]);
        check($sformatf("tbl%0d lsb bit%0d", t, i), ser_b, tbl[t].seq_lsb[7 - i]);
        check($sformatf("tbl%0d start%0d", t, i), ws_a, i == 0);
        check($sformatf("tbl%0d done%0d", t, i),  wd_a, i == 7);
        step();
      end
      check("tbl after ser_valid", sv_a, 1'b0);
      check("tbl after busy", busy_a, 1'b0);
      check("tbl idle_a after", ser_a, 1'b0);
      check("tbl idle_b after", ser_b, 1'b1);
      step();
    end

    // back-to-back A5 then 0F with din_valid held high
    send0(8'hA5, w);
    din_a = 8'h0F;
    for (int i = 0; i < 16; i++) begin
      got[15 - i] = ser_a;
      st[15 - i]  = ws_a;
      dn[15 - i]  = wd_a;
      check("b2b ser_valid", sv_a, 1'b1);
      step();
      if (i == 0) valid_a = 1'b0;
    end
    check("b2b bits", got, 16'hA50F);
    check("b2b word_start", st, 16'h8080);
    check("b2b word_done", dn, 16'h0101);
    check("b2b end valid", sv_a, 1'b0);

    // backpressure: third word waits for the hold register to drain
    wait_idle();
    rec0.delete();
    send0(8'hFF, w);
    din_a = 8'h00;
    step();
    check("bp ready drop", ready_a, 1'b0);
    send0(8'h81, w);
    check("bp third accept cycles", w, 8);
    valid_a = 1'b0;
    wait_idle();
    check("bp stream length", rec0.size(), 24);
    exp24 = {8'hFF, 8'h00, 8'h81};
    errs = 0;
    for (int i = 0; i < 24 && i < rec0.size(); i++)
      if (rec0[i] !== exp24[23 - i]) errs++;
    check("bp stream bits", errs, 0);

    // reset during the 4th bit of A5 with 3C held
    send0(8'hA5, w);
    din_a = 8'h3C;
    step();
    valid_a = 1'b0;
    step();
    step();
    check("rst pre hold full", ready_a, 1'b0);
    rst = 1'b1;
    #1;
    chk_reset_a("midword reset");
    step();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check("rst quiet", sv_a, 1'b0);
      step();
    end
    rec0.delete();
    send0(8'h81, w);
    valid_a = 1'b0;
    wait_idle();
    check("rst new word length", rec0.size(), 8);
    exp8 = 8'h81;
    errs = 0;
    for (int i = 0; i < 8 && i < rec0.size(); i++)
      if (rec0[i] !== exp8[7 - i]) errs++;
    check("rst new word bits", errs, 0);

    // Mealy "101" detector on the serial stream; idle line 0 precedes the word
    step();
    send0(8'hAA, w);
    valid_a = 1'b0;
    h1 = 1'b0;
    h2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      det = ser_a & !h1 & h2;
      check($sformatf("mealy bit%0d", i + 1), det, (i == 2 || i == 4 || i == 6));
      h2 = h1;
      h1 = ser_a;
      step();
    end

    // randomized traffic on both instances, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      valid_a = ($urandom_range(0, 9) < 6);
      valid_b = ($urandom_range(0, 9) < 6);
      din_a   = 8'($urandom);
      din_b   = 8'($urandom);
      step();
    end
    valid_a = 1'b0;
    valid_b = 1'b0;
    wait_idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the serial sequence detectors (the "101" Mealy/Moore detectors). It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on `ser_out`, which drives the detector's `in` port directly. A one-word holding register lets consecutive words stream with no idle bit between them. Between words the line is driven to a fixed idle level.

## Interface
- `WIDTH`, default 8: word width in bits; legal range ≥ 2.
- `MSB_FIRST`, default 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- `IDLE_BIT`, default 1'b0: level driven on `ser_out` when no word is being shifted.

- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `din`, input, WIDTH: parallel word; sampled on the handshake edge.
- `din_valid`, input, 1: `din` holds a word.
- `din_ready`, output, 1: the block can accept a word; equals `!hold_full`, decoded from registered state only.
- `ser_out`, output, 1: serial bit, registered; goes to the detector `in`.
- `ser_valid`, output, 1: `ser_out` carries a word bit, registered.
- `word_start`, output, 1: high during the first bit of each word, registered.
- `word_done`, output, 1: high during the last bit of each word, registered.
- `busy`, output, 1: equals `ser_valid | hold_full`.

## Operation
- **Storage:** shift register `sreg` (WIDTH bits), bit counter `cnt` ($clog2(WIDTH) bits), holding register `hold` with flag `hold_full`.
- **Handshake:** a word is accepted on a rising edge where `din_valid && din_ready`. `din_valid` may drop without acceptance, and no state changes in that case.
- **Shifter FSM, IDLE state:** `ser_valid`=0 and `ser_out`=IDLE_BIT.
  - If `hold_full`, load from `hold` and clear `hold_full`.
  - Otherwise, if a word is accepted, load it directly.
  - Any load sets `cnt`=0 and moves to SHIFT.
- **Shifter FSM, SHIFT state:** one bit is presented per cycle. `cnt` increments each edge.
- **Last bit (`cnt`==WIDTH-1):**
  - If `hold_full`, load from `hold` and stay in SHIFT.
  - Otherwise, if a word is accepted on this edge, load it directly and stay in SHIFT.
  - Otherwise, go to IDLE.
- **Routing of accepted words:** an accepted word goes to the shifter when the shifter is loading on that edge and `hold` is empty. Otherwise it goes to `hold` and sets `hold_full`.
- **Simultaneous events:** on the edge where `hold` drains into the shifter, `din_ready` is 0, so no acceptance can collide with the drain.
- **Bit order:** MSB_FIRST=1 gives `din[WIDTH-1]` down to `din[0]`. MSB_FIRST=0 gives `din[0]` up to `din[WIDTH-1]`.
- **Flags:**
  - `word_start`=1 exactly in the cycle where `cnt`==0 in SHIFT.
  - `word_done`=1 exactly in the cycle where `cnt`==WIDTH-1 in SHIFT.
  - Both are 1-cycle pulses per word.
- **Reset values (immediate on `rst` assertion):**
  - Outputs: `ser_out`=IDLE_BIT; `ser_valid`=0; `word_start`=0; `word_done`=0; `busy`=0; `din_ready`=1.
  - Internal state: FSM=IDLE; `cnt`=0; `hold_full`=0.
- **Reset mid-word:** the word in flight and any held word are discarded, with no partial completion. The first handshake after `rst` deasserts starts a clean word.

## Timing
- **Latency:** for a word accepted at edge k with the shifter free, bit 0 of the sequence is on `ser_out` from edge k until edge k+1. The last bit is on `ser_out` from edge k+WIDTH-1 until edge k+WIDTH.
- **Throughput:** one bit per clock. With `hold` prefilled, the first bit of word n+1 follows the last bit of word n in the next cycle, with no gap.
- **Capacity:** at most 2 words resident, one in `sreg` and one in `hold`.
- **Ready after drain:** when `hold` drains into the shifter at edge j, `din_ready` returns to 1 after edge j.
- **Idle line:** `ser_out` is IDLE_BIT in every cycle where `ser_valid`=0. The detector therefore sees a continuous stream, and IDLE_BIT=0 walks it back to its start state.

## Test plan
- **Single word:** after reset, WIDTH=8, MSB_FIRST=1, send `din`=8'b1010_0101 once.
  - `ser_out` = 1,0,1,0,0,1,0,1 in the 8 cycles after acceptance.
  - `word_start` is high in cycle 1 only and `word_done` in cycle 8 only.
  - `ser_out` then returns to 0, with `ser_valid`=0 and `busy`=0.
- **Back-to-back words:** hold `din_valid` high and send 8'hA5 then 8'h0F.
  - 16 contiguous valid bits: 10100101 00001111.
  - `word_start` pulses at cycles 1 and 9; `word_done` pulses at cycles 8 and 16; no gap between words.
- **Backpressure:** offer three words 8'hFF, 8'h00, 8'h81 continuously.
  - `din_ready` drops to 0 after the second acceptance.
  - The third word is accepted only on the edge after `hold` drains.
  - All 24 bits appear in order.
- **Reset mid-word:** assert `rst` for 1 cycle during bit 4 of 8'hA5 while `hold` contains 8'h3C.
  - All outputs immediately take their reset values and nothing further is emitted.
  - A new word 8'h81 then emits 1,0,0,0,0,0,0,1.
- **LSB-first variant:** with MSB_FIRST=0, send 8'h01.
  - `ser_out` = 1,0,0,0,0,0,0,0.
  - With IDLE_BIT=1, the line reads 1 before and after the word while `ser_valid`=0.
- **Chained with the Mealy "101" detector:** feed 8'b1010_1010.
  - The detector `out` pulses during the 3rd, 5th and 7th serialized bits.
